// File: rtl/mtr_drv.sv
// Dual half-bridge motor gate driver: one shared 11-bit PWM counter, offset-binary
// duty from signed PID speed, and a per-channel dead-time FSM that never overlaps H and L.

module mtr_drv_chan #(
    parameter int NONOVERLAP = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] cnt,
    input  logic [10:0] spd,
    output logic        drv_h,
    output logic        drv_l
);
    typedef enum logic [1:0] {
        DEAD    = 2'd0,
        DRIVE_H = 2'd1,
        DRIVE_L = 2'd2
    } state_t;

    localparam logic [5:0] DCNT_LAST = 6'(NONOVERLAP - 1);

    logic [10:0] duty_q;
    logic        raw_q;
    logic        raw_d;
    logic        change;
    state_t      state;
    state_t      state_nxt;
    logic [5:0]  dcnt;
    logic [5:0]  dcnt_nxt;

    // Duty only updates at the period boundary so a speed change never splits a pulse.
    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values, independent of the order the always_ff blocks are evaluated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_q <= 11'd1024;
            raw_q  <= 1'b0;
            raw_d  <= 1'b0;
        end else begin
            if (cnt == 11'd2047) begin
                duty_q <= {~spd[10], spd[9:0]};
            end
            raw_q <= (cnt < duty_q);
            raw_d <= raw_q;
        end
    end

    assign change = raw_q ^ raw_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= DEAD;
            dcnt  <= 6'd0;
        end else begin
            state <= state_nxt;
            dcnt  <= dcnt_nxt;
        end
    end

    // NOTE: hold values are assigned first so every path writes both outputs;
    // without these defaults the missing branches would infer latches.
    always_comb begin
        state_nxt = state;
        dcnt_nxt  = dcnt;
        case (state)
            DEAD: begin
                if (change) begin
                    dcnt_nxt = 6'd0;
                end else if (dcnt == DCNT_LAST) begin
                    state_nxt = raw_q ? DRIVE_H : DRIVE_L;
                    dcnt_nxt  = 6'd0;
                end else begin
                    dcnt_nxt = dcnt + 6'd1;
                end
            end
            DRIVE_H, DRIVE_L: begin
                if (change) begin
                    state_nxt = DEAD;
                    dcnt_nxt  = 6'd0;
                end
            end
            default: begin
                state_nxt = DEAD;
                dcnt_nxt  = 6'd0;
            end
        endcase
    end

    // Gates decode straight from the async-reset state register, so reset forces
    // both low immediately and the two can never be high together.
    assign drv_h = (state == DRIVE_H);
    assign drv_l = (state == DRIVE_L);

endmodule

module mtr_drv #(
    parameter int NONOVERLAP = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] lft_spd,
    input  logic [10:0] rght_spd,
    output logic        lftH,
    output logic        lftL,
    output logic        rghtH,
    output logic        rghtL,
    output logic        pwm_sync
);
    logic [10:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 11'd0;
        end else begin
            cnt <= cnt + 11'd1;
        end
    end

    assign pwm_sync = (cnt == 11'd0);

    mtr_drv_chan #(
        .NONOVERLAP (NONOVERLAP)
    ) u_lft (
        .clk   (clk),
        .rst_n (rst_n),
        .cnt   (cnt),
        .spd   (lft_spd),
        .drv_h (lftH),
        .drv_l (lftL)
    );

    mtr_drv_chan #(
        .NONOVERLAP (NONOVERLAP)
    ) u_rght (
        .clk   (clk),
        .rst_n (rst_n),
        .cnt   (cnt),
        .spd   (rght_spd),
        .drv_h (rghtH),
        .drv_l (rghtL)
    );

endmodule

// File: tb/tb_mtr_drv.sv
// Scoreboard bench for mtr_drv: stimulus queues expected per-period gate-high counts,
// a monitor tallies each pwm_sync-delimited window and checks dead time continuously.

module tb_mtr_drv;
    localparam int NONOVERLAP = 32;

    typedef struct {
        int lh;
        int ll;
        int rh;
        int rl;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] lft_spd;
    logic [10:0] rght_spd;
    logic        lftH, lftL, rghtH, rghtL, pwm_sync;

    int   checks = 0;
    int   errors = 0;
    int   viol   = 0;
    exp_t sb_q[$];

    mtr_drv #(
        .NONOVERLAP (NONOVERLAP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .lft_spd  (lft_spd),
        .rght_spd (rght_spd),
        .lftH     (lftH),
        .lftL     (lftL),
        .rghtH    (rghtH),
        .rghtL    (rghtL),
        .pwm_sync (pwm_sync)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int lh, input int ll, input int rh, input int rl);
        exp_t e;
        e.lh = lh;
        e.ll = ll;
        e.rh = rh;
        e.rl = rl;
        sb_q.push_back(e);
    endtask

    // Monitor: window = one cnt 0..2047 period, sampled on the falling edge.
    int   cnt_lh, cnt_ll, cnt_rh, cnt_rl, cnt_sync;
    int   period_idx = 0;
    bit   in_win = 1'b0;
    logic prev_h [2];
    logic prev_l [2];
    int   run    [2];

    initial begin : monitor
        logic h [2];
        logic l [2];
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            prev_h[i] = 1'b0;
            prev_l[i] = 1'b0;
            run[i]    = 0;
        end
        forever begin
            @(negedge clk);
            h[0] = lftH;
            l[0] = lftL;
            h[1] = rghtH;
            l[1] = rghtL;
            if (!rst_n) begin
                in_win = 1'b0;
                for (int i = 0; i < 2; i++) begin
                    if (h[i] || l[i]) viol++;
                    prev_h[i] = 1'b0;
                    prev_l[i] = 1'b0;
                    run[i]    = 0;
                end
            end else begin
                if (pwm_sync) begin
                    if (in_win) begin
                        if (sb_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL sb_underflow: period %0d completed with no expectation queued", period_idx);
                        end else begin
                            e = sb_q.pop_front();
                            check($sformatf("P%0d lftH_cycles", period_idx), cnt_lh, e.lh);
                            check($sformatf("P%0d lftL_cycles", period_idx), cnt_ll, e.ll);
                            check($sformatf("P%0d rghtH_cycles", period_idx), cnt_rh, e.rh);
                            check($sformatf("P%0d rghtL_cycles", period_idx), cnt_rl, e.rl);
                            check($sformatf("P%0d pwm_sync_pulses", period_idx), cnt_sync, 1);
                        end
                        period_idx++;
                    end
                    in_win   = 1'b1;
                    cnt_lh   = 0;
                    cnt_ll   = 0;
                    cnt_rh   = 0;
                    cnt_rl   = 0;
                    cnt_sync = 0;
                end
                if (in_win) begin
                    cnt_lh   += int'(lftH);
                    cnt_ll   += int'(lftL);
                    cnt_rh   += int'(rghtH);
                    cnt_rl   += int'(rghtL);
                    cnt_sync += int'(pwm_sync);
                end
                // Overlap and dead-time rule: any gate rising needs NONOVERLAP idle samples before it.
                for (int i = 0; i < 2; i++) begin
                    if (h[i] && l[i]) viol++;
                    if (((h[i] && !prev_h[i]) || (l[i] && !prev_l[i])) && run[i] < NONOVERLAP) viol++;
                    run[i]    = (h[i] || l[i]) ? 0 : run[i] + 1;
                    prev_h[i] = h[i];
                    prev_l[i] = l[i];
                end
            end
        end
    end

    initial begin : stimulus
        rst_n    = 1'b0;
        lft_spd  = 11'h000;
        rght_spd = 11'h000;
        repeat (5) @(posedge clk);
        #1;
        check("rst lftH", int'(lftH), 0);
        check("rst lftL", int'(lftL), 0);
        check("rst rghtH", int'(rghtH), 0);
        check("rst rghtL", int'(rghtL), 0);
        check("rst pwm_sync", int'(pwm_sync), 1);

        @(posedge clk);
        #1 rst_n = 1'b1;

        // P0: reset duty 1024 both; both gates idle at cnt 0,1 after release.
        push(992, 990, 992, 990);
        wait_cyc(1000);
        lft_spd  = 11'h3FF;   // +1023
        rght_spd = 11'h400;   // -1024
        wait_cyc(1048);
        // P1: left 2047 after an L tail, right duty 0.
        push(2014, 2, 0, 2048);
        wait_cyc(2048);
        // P2: steady full scale: 33 dead cycles left, right L continuous.
        push(2015, 0, 0, 2048);
        wait_cyc(1000);
        lft_spd  = 11'h000;
        rght_spd = 11'h000;
        wait_cyc(1048);
        // P3: left leaves 2047 with H still on at cnt 0.
        push(993, 990, 992, 992);
        wait_cyc(2048);
        // P4: steady zero speed; mid-period change must not affect this period.
        push(992, 992, 992, 992);
        wait_cyc(100);
        lft_spd  = 11'h200;   // +512
        rght_spd = 11'h600;   // -512
        wait_cyc(1948);
        // P5: left duty 1536, right duty 512.
        push(1504, 480, 480, 1504);
        wait_cyc(2048);
        // P6: interrupted by reset at cnt 500; no expectation queued.
        wait_cyc(500);
        check("pre_rst lftH", int'(lftH), 1);
        rst_n = 1'b0;
        #1;
        check("async_rst lftH", int'(lftH), 0);
        check("async_rst lftL", int'(lftL), 0);
        check("async_rst rghtH", int'(rghtH), 0);
        check("async_rst rghtL", int'(rghtL), 0);
        check("async_rst pwm_sync", int'(pwm_sync), 1);
        rght_spd = 11'h40A;   // -1014 -> duty 10, shorter than the dead time
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        // P7: duty back at reset value 1024 regardless of speed inputs.
        push(992, 990, 992, 990);
        wait_cyc(2048);
        // P8/P9: left 1536; right 10-cycle pulse suppressed, dead window stretched to 42.
        push(1504, 480, 0, 2006);
        wait_cyc(2048);
        push(1504, 480, 0, 2006);
        wait_cyc(2048);

        @(negedge clk);
        #1;
        check("sb_drained", sb_q.size(), 0);
        check("gate_overlap_or_deadtime_violations", viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
